// File: rtl/y86_writeback_regfile.sv
// ---------------------------------------------------------------------------
// y86_writeback_regfile
//
// Purpose:
//   Write side of the Y86-64 SEQ register file. It decodes the E and M
//   destination registers from the current instruction, commits valE/valM
//   on the rising clock edge, and keeps a sticky processor status. Once a
//   halt or fault has been recorded, the architectural state is frozen until
//   reset.
//
// Parameters:
//   DATA_W      register/data width (default 64)
//   STACK_INIT  reset value of %rsp, register 4 (default 'h200)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   instr_valid   instruction and results valid this cycle
//   icode, ifun   instruction and function codes
//   rA, rB        register specifiers, 4'hF = none
//   valE, valM    ALU result and data-memory read result
//   cnd           condition flag from execute
//   imem_error    instruction fetch address error
//   dmem_error    data memory address error
//   rm0..rm14     architectural registers (registered)
//   dstE, dstM    combinational destination registers, 4'hF = none
//   stat          00 AOK, 01 HLT, 10 ADR, 11 INS (registered)
//   halted        high whenever stat != AOK
//
// Optional feature (macro WB_RETIRE_CNT_EN):
//   Adds a 64-bit output 'retired' that counts committed, non-faulting
//   instructions. It wraps modulo 2^64.
// ---------------------------------------------------------------------------
module y86_writeback_regfile #(
  parameter int                 DATA_W     = 64,
  parameter logic [DATA_W-1:0]  STACK_INIT = 'h200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              cnd,
  input  logic              imem_error,
  input  logic              dmem_error,
  output logic [DATA_W-1:0] rm0,
  output logic [DATA_W-1:0] rm1,
  output logic [DATA_W-1:0] rm2,
  output logic [DATA_W-1:0] rm3,
  output logic [DATA_W-1:0] rm4,
  output logic [DATA_W-1:0] rm5,
  output logic [DATA_W-1:0] rm6,
  output logic [DATA_W-1:0] rm7,
  output logic [DATA_W-1:0] rm8,
  output logic [DATA_W-1:0] rm9,
  output logic [DATA_W-1:0] rm10,
  output logic [DATA_W-1:0] rm11,
  output logic [DATA_W-1:0] rm12,
  output logic [DATA_W-1:0] rm13,
  output logic [DATA_W-1:0] rm14,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [1:0]        stat,
  output logic              halted
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retired
`endif
);

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_ADR = 2'b10,
    STAT_INS = 2'b11
  } stat_t;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  logic [DATA_W-1:0] r_regs [0:14];
  stat_t             r_stat;
  stat_t             w_nextStat;
  stat_t             w_instrStat;
  logic              w_commit;
  logic              w_unusedIfun;

  // The function code carries no information the write side needs: every
  // valid icode accepts any ifun at this stage.
  assign w_unusedIfun = ^ifun;

  // E destination: conditional moves only write when the condition held;
  // stack operations always update %rsp.
  always_comb begin
    dstE = REG_NONE;
    case (icode)
      4'h2:                   dstE = cnd ? rB : REG_NONE;
      4'h3, 4'h6:             dstE = rB;
      4'h8, 4'h9, 4'hA, 4'hB: dstE = REG_RSP;
      default:                dstE = REG_NONE;
    endcase
  end

  // M destination: only mrmovq and popq load a register from memory.
  always_comb begin
    dstM = REG_NONE;
    if (icode == 4'h5 || icode == 4'hB) begin
      dstM = rA;
    end
  end

  // Status of the instruction presented this cycle. A fetch error outranks
  // everything, because the icode itself cannot be trusted then.
  always_comb begin
    w_instrStat = STAT_AOK;
    if (imem_error) begin
      w_instrStat = STAT_ADR;
    end else if (icode > 4'hB) begin
      w_instrStat = STAT_INS;
    end else if (icode == 4'h0) begin
      w_instrStat = STAT_HLT;
    end else if (dmem_error) begin
      w_instrStat = STAT_ADR;
    end
  end

  assign w_commit = instr_valid && (r_stat == STAT_AOK) && (w_instrStat == STAT_AOK);

  // Sticky status: the first non-AOK instruction status is latched and all
  // later instructions are ignored until reset.
  always_comb begin
    w_nextStat = r_stat;
    if (instr_valid && (r_stat == STAT_AOK) && (w_instrStat != STAT_AOK)) begin
      w_nextStat = w_instrStat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= STAT_AOK;
    end else begin
      r_stat <= w_nextStat;
    end
  end

  // Register file update. valM is tested first so that a collision such as
  // popq %rsp leaves the popped value in the register rather than the
  // incremented stack pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= (i == 4) ? STACK_INIT : '0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < 15; i++) begin
        if (dstM == 4'(i)) begin
          r_regs[i] <= valM;
        end else if (dstE == 4'(i)) begin
          r_regs[i] <= valE;
        end
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retired;

  // Counts only instructions that actually commit; halts and faults are
  // excluded. Natural binary overflow provides the wrap to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_commit) begin
      r_retired <= r_retired + 64'd1;
    end
  end

  assign retired = r_retired;
`endif

  assign rm0    = r_regs[0];
  assign rm1    = r_regs[1];
  assign rm2    = r_regs[2];
  assign rm3    = r_regs[3];
  assign rm4    = r_regs[4];
  assign rm5    = r_regs[5];
  assign rm6    = r_regs[6];
  assign rm7    = r_regs[7];
  assign rm8    = r_regs[8];
  assign rm9    = r_regs[9];
  assign rm10   = r_regs[10];
  assign rm11   = r_regs[11];
  assign rm12   = r_regs[12];
  assign rm13   = r_regs[13];
  assign rm14   = r_regs[14];
  assign stat   = r_stat;
  assign halted = (r_stat != STAT_AOK);

endmodule

// File: tb/tb_y86_writeback_regfile.sv
// ---------------------------------------------------------------------------
// tb_y86_writeback_regfile
//
// Directed testbench for y86_writeback_regfile. Each instruction is driven
// on the falling clock edge and committed on the following rising edge. The
// expected register contents are tracked in a small shadow array that is
// updated by hand after each step.
// ---------------------------------------------------------------------------
module tb_y86_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        cnd;
  logic        imem_error;
  logic        dmem_error;
  logic [63:0] rm0, rm1, rm2, rm3, rm4, rm5, rm6, rm7;
  logic [63:0] rm8, rm9, rm10, rm11, rm12, rm13, rm14;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [1:0]  stat;
  logic        halted;

  logic [63:0] rmVec [15];
  logic [63:0] expRegs [15];
  int          checkCount;
  int          failCount;

  y86_writeback_regfile #(
    .DATA_W     (64),
    .STACK_INIT (64'h200)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .icode       (icode),
    .ifun        (ifun),
    .rA          (rA),
    .rB          (rB),
    .valE        (valE),
    .valM        (valM),
    .cnd         (cnd),
    .imem_error  (imem_error),
    .dmem_error  (dmem_error),
    .rm0         (rm0),
    .rm1         (rm1),
    .rm2         (rm2),
    .rm3         (rm3),
    .rm4         (rm4),
    .rm5         (rm5),
    .rm6         (rm6),
    .rm7         (rm7),
    .rm8         (rm8),
    .rm9         (rm9),
    .rm10        (rm10),
    .rm11        (rm11),
    .rm12        (rm12),
    .rm13        (rm13),
    .rm14        (rm14),
    .dstE        (dstE),
    .dstM        (dstM),
    .stat        (stat),
    .halted      (halted)
  );

  assign rmVec[0]  = rm0;
  assign rmVec[1]  = rm1;
  assign rmVec[2]  = rm2;
  assign rmVec[3]  = rm3;
  assign rmVec[4]  = rm4;
  assign rmVec[5]  = rm5;
  assign rmVec[6]  = rm6;
  assign rmVec[7]  = rm7;
  assign rmVec[8]  = rm8;
  assign rmVec[9]  = rm9;
  assign rmVec[10] = rm10;
  assign rmVec[11] = rm11;
  assign rmVec[12] = rm12;
  assign rmVec[13] = rm13;
  assign rmVec[14] = rm14;

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compares every architectural register against the shadow copy.
  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < 15; i++) begin
      checkOutput($sformatf("%s_rm%0d", tag, i), rmVec[i], expRegs[i]);
    end
  endtask

  task automatic resetExpected();
    for (int i = 0; i < 15; i++) begin
      expRegs[i] = (i == 4) ? 64'h200 : 64'h0;
    end
  endtask

  // Presents one instruction on the falling edge; the caller may check the
  // combinational destinations before calling commitEdge.
  task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic [63:0] e, input logic [63:0] m,
                               input logic c, input logic imErr,
                               input logic dmErr, input logic valid);
    @(negedge clk);
    icode       = ic;
    ifun        = fn;
    rA          = a;
    rB          = b;
    valE        = e;
    valM        = m;
    cnd         = c;
    imem_error  = imErr;
    dmem_error  = dmErr;
    instr_valid = valid;
    #1;
  endtask

  // Lets the presented instruction commit, then samples 1 ns after the edge.
  task automatic commitEdge();
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    imem_error  = 1'b0;
    dmem_error  = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    resetExpected();
  endtask

  initial begin
    checkCount  = 0;
    failCount   = 0;
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    icode       = 4'h1;
    ifun        = 4'h0;
    rA          = 4'hF;
    rB          = 4'hF;
    valE        = 64'h0;
    valM        = 64'h0;
    cnd         = 1'b0;
    imem_error  = 1'b0;
    dmem_error  = 1'b0;

    // Asynchronous reset pulse, checked before any commit can happen.
    #1;
    rst_n = 1'b0;
    #5;
    resetExpected();
    checkAllRegs("reset");
    checkOutput("reset_stat", 64'(stat), 64'h0);
    checkOutput("reset_halted", 64'(halted), 64'h0);
    rst_n = 1'b1;

    // irmovq $0x55, %rbx
    applyStimulus(4'h3, 4'h0, 4'hF, 4'h3, 64'h55, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("irmovq_dstE", 64'(dstE), 64'h3);
    checkOutput("irmovq_dstM", 64'(dstM), 64'hF);
    commitEdge();
    expRegs[3] = 64'h55;
    checkAllRegs("irmovq");

    // Same irmovq with instr_valid low must leave everything alone.
    applyStimulus(4'h3, 4'h0, 4'hF, 4'h7, 64'hDEAD, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    commitEdge();
    checkOutput("novalid_rm7", rm7, 64'h0);
    checkOutput("novalid_stat", 64'(stat), 64'h0);

    // cmovle %rcx, %rdx, condition false
    applyStimulus(4'h2, 4'h1, 4'h1, 4'h2, 64'h77, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("cmov_nc_dstE", 64'(dstE), 64'hF);
    commitEdge();
    checkAllRegs("cmov_nc");

    // cmovle %rcx, %rdx, condition true
    applyStimulus(4'h2, 4'h1, 4'h1, 4'h2, 64'h77, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("cmov_c_dstE", 64'(dstE), 64'h2);
    commitEdge();
    expRegs[2] = 64'h77;
    checkAllRegs("cmov_c");

    // pushq and jXX destinations (combinational only)
    applyStimulus(4'hA, 4'h0, 4'h3, 4'hF, 64'h1F8, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pushq_dstE", 64'(dstE), 64'h4);
    checkOutput("pushq_dstM", 64'(dstM), 64'hF);
    applyStimulus(4'h7, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("jxx_dstE", 64'(dstE), 64'hF);

    // popq %rbp: both ports write on the same edge
    applyStimulus(4'hB, 4'h0, 4'h5, 4'hF, 64'h208, 64'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("popq_dstE", 64'(dstE), 64'h4);
    checkOutput("popq_dstM", 64'(dstM), 64'h5);
    commitEdge();
    expRegs[5] = 64'hAA;
    expRegs[4] = 64'h208;
    checkAllRegs("popq_rbp");

    // popq %rsp: collision, memory value wins
    applyStimulus(4'hB, 4'h0, 4'h4, 4'hF, 64'h210, 64'hBB, 1'b0, 1'b0, 1'b0, 1'b1);
    commitEdge();
    expRegs[4] = 64'hBB;
    checkAllRegs("popq_rsp");

    // halt
    applyStimulus(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    commitEdge();
    checkOutput("halt_stat", 64'(stat), 64'h1);
    checkOutput("halt_halted", 64'(halted), 64'h1);
    checkAllRegs("halt");

    // irmovq after halt is ignored
    applyStimulus(4'h3, 4'h0, 4'hF, 4'h1, 64'h9, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    commitEdge();
    checkOutput("posthalt_rm1", rm1, 64'h0);
    checkOutput("posthalt_stat", 64'(stat), 64'h1);

    // Fresh reset, then irmovq with a data memory error
    pulseReset();
    checkAllRegs("reset2");
    applyStimulus(4'h3, 4'h0, 4'hF, 4'h6, 64'h99, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    commitEdge();
    checkOutput("dmem_stat", 64'(stat), 64'h2);
    checkOutput("dmem_rm6", rm6, 64'h0);

    // Fetch error outranks an invalid icode
    pulseReset();
    applyStimulus(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    commitEdge();
    checkOutput("imem_prio_stat", 64'(stat), 64'h2);

    // Invalid icode
    pulseReset();
    applyStimulus(4'hC, 4'h0, 4'hF, 4'h2, 64'h5, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    commitEdge();
    checkOutput("ins_stat", 64'(stat), 64'h3);
    checkOutput("ins_halted", 64'(halted), 64'h1);
    checkOutput("ins_rm2", rm2, 64'h0);

    // Reset mid-run clears status without waiting for a clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_stat", 64'(stat), 64'h0);
    checkOutput("midreset_halted", 64'(halted), 64'h0);
    checkOutput("midreset_rm4", rm4, 64'h200);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
